// File: rtl/pio_port_peer_pkg.sv
// Shared definitions for the pin-bus peer: FSM state encodings and the
// direction-control values seen on dir_ctl_i.
package pio_port_peer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_SETUP = 3'd3,
        ST_ACK      = 3'd4
    } state_t;

    localparam logic DIR_CORE_DRIVES = 1'b0;
    localparam logic DIR_PEER_DRIVES = 1'b1;

    // Setup counter width: SETUP_CYC is limited to 0..15.
    localparam int SETUP_CNT_W = 4;

endpackage

// File: rtl/pio_port_peer_rx_fifo.sv
// Circular RX FIFO for bytes captured from the pin bus.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request/data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   head              entry at the read pointer, 0 when empty
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module pio_port_peer_rx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pio_port_peer.sv
// External-side peer of a core's bidirectional I/O port on a shared
// tri-state pin bus, with a stb/ack handshake.
//   dir_ctl_i=0: core drives pins, byte is captured into the RX FIFO.
//   dir_ctl_i=1: byte from the TX hold register is driven onto the pins.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   pin_data_io           shared pin bus (driven only during a read)
//   dir_ctl_i, stb_i      core direction and strobe
//   ack_o                 transfer done, held until stb_i falls
//   rx_data_o/valid/ready/count   RX FIFO head, not-empty, pop, occupancy
//   tx_data_i/valid/ready TX hold register load handshake
//   err_o                 one-cycle pulse when direction changes mid-transfer
module pio_port_peer
    import pio_port_peer_pkg::*;
#(
    parameter int DW        = 8,
    parameter int RX_DEPTH  = 4,
    parameter int SETUP_CYC = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    inout  wire  [DW-1:0]               pin_data_io,
    input  logic                        dir_ctl_i,
    input  logic                        stb_i,
    output logic                        ack_o,
    output logic [DW-1:0]               rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(RX_DEPTH):0]   rx_count_o,
    input  logic [DW-1:0]               tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic                        err_o
);
    state_t                 state_q, state_d;
    logic                   stb_q, stb_edge;
    logic                   dir_lat;
    logic [DW-1:0]          cap_reg;
    logic [DW-1:0]          hold_data;
    logic                   hold_full;
    logic [SETUP_CNT_W-1:0] cnt;
    logic                   err_q;
    logic                   abort, room;
    logic                   push, consume, drive_raw, drive_en;
    logic [DW-1:0]          push_data;
    logic                   fifo_full, fifo_empty;

    assign stb_edge = stb_i & ~stb_q;
    // A pop in the same cycle makes room even when the FIFO is full.
    assign room     = ~fifo_full | rx_ready_i;
    assign abort    = (state_q != ST_IDLE) && (dir_ctl_i != dir_lat);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (stb_edge) begin
                    if (dir_ctl_i == DIR_CORE_DRIVES) state_d = room ? ST_ACK : ST_WR_WAIT;
                    else                              state_d = hold_full ? ST_RD_SETUP : ST_RD_WAIT;
                end
            end
            ST_WR_WAIT:  if (room)                       state_d = ST_ACK;
            ST_RD_WAIT:  if (hold_full)                  state_d = ST_RD_SETUP;
            ST_RD_SETUP: if (cnt == SETUP_CNT_W'(SETUP_CYC)) state_d = ST_ACK;
            ST_ACK:      if (!stb_i)                     state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase
        // Direction flip while busy wins over every other transition.
        if (abort) state_d = ST_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ack_o     = (state_q == ST_ACK);
        drive_raw = (state_q == ST_RD_SETUP) ||
                    ((state_q == ST_ACK) && (dir_lat == DIR_PEER_DRIVES));
        push      = 1'b0;
        push_data = cap_reg;
        if (state_q == ST_IDLE) begin
            push      = stb_edge && (dir_ctl_i == DIR_CORE_DRIVES) && room;
            push_data = pin_data_io;
        end else if (state_q == ST_WR_WAIT) begin
            push      = room && !abort;
        end
        consume   = (state_q == ST_ACK) && !stb_i && !abort &&
                    (dir_lat == DIR_PEER_DRIVES);
    end

    // Never drive while the core might be driving, whatever the FSM thinks.
    assign drive_en    = drive_raw && (dir_ctl_i == DIR_PEER_DRIVES);
    assign pin_data_io = drive_en ? hold_data : 'z;

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q     <= 1'b0;
            dir_lat   <= DIR_CORE_DRIVES;
            cap_reg   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            err_q     <= 1'b0;
        end else begin
            stb_q <= stb_i;
            err_q <= abort;
            if (state_q == ST_IDLE && stb_edge) begin
                dir_lat <= dir_ctl_i;
                cap_reg <= pin_data_io;
            end
            // Counter restarts whenever RD_SETUP is (re)entered.
            cnt <= (state_q == ST_RD_SETUP) ? cnt + 1'b1 : '0;
            // consume only fires with the hold full, so load can't collide.
            if (consume) begin
                hold_full <= 1'b0;
            end else if (tx_valid_i && !hold_full) begin
                hold_data <= tx_data_i;
                hold_full <= 1'b1;
            end
        end
    end

    assign err_o      = err_q;
    assign tx_ready_o = ~hold_full;
    assign rx_valid_o = ~fifo_empty;

    pio_port_peer_rx_fifo #(
        .DW    (DW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (rx_ready_i),
        .head      (rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count_o)
    );

endmodule

// File: tb/tb_pio_port_peer.sv
// Self-checking bench for pio_port_peer: directed scenarios plus a randomized
// sequence checked against a queue-based model of the FIFO and hold register.
module tb_pio_port_peer;
    localparam int SETUP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst, dir, stb, rx_ready, tx_valid;
    logic [7:0] tx_data;
    logic       tb_drv;
    logic [7:0] tb_pin;
    wire  [7:0] pins;
    logic       ack, rx_valid, tx_ready, err;
    logic [7:0] rx_data;
    logic [2:0] rx_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];   // model of FIFO contents

    assign pins = tb_drv ? tb_pin : 8'hzz;

    always #5 clk = ~clk;

    pio_port_peer #(.DW(8), .RX_DEPTH(4), .SETUP_CYC(SETUP_CYC)) dut (
        .clk_i(clk), .rst_i(rst), .pin_data_io(pins), .dir_ctl_i(dir),
        .stb_i(stb), .ack_o(ack), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .rx_count_o(rx_count), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .err_o(err)
    );

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Core write; optional pop during the strobe cycle. lat = cycles until ack (20 = timeout).
    task automatic wr(input logic [7:0] b, input logic pop, output int lat);
        dir = 1'b0; tb_drv = 1'b1; tb_pin = b; stb = 1'b1; rx_ready = pop;
        tick;
        rx_ready = 1'b0; tb_drv = 1'b0; lat = 1;
        while (!ack && lat < 20) begin tick; lat++; end
        stb = 1'b0; tick;
    endtask

    // Load hold with b, then core read. pv = pins one cycle after the strobe.
    task automatic rd(input logic [7:0] b, output logic [7:0] pv, output int lat);
        tx_data = b; tx_valid = 1'b1; tick; tx_valid = 1'b0;
        dir = 1'b1; stb = 1'b1; tick;
        pv = pins; lat = 1;
        while (!ack && lat < 20) begin tick; lat++; end
        stb = 1'b0; tick;
        dir = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; dir = 1'b0; stb = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
        tx_data = '0; tb_drv = 1'b0; tb_pin = '0;
        repeat (3) tick;
        rst = 1'b0; tick;
        total++; if (ack !== 1'b0)      begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_write;
        dir = 1'b0; tb_drv = 1'b1; tb_pin = 8'hA5; stb = 1'b1;
        tick;
        tb_drv = 1'b0;
        total++; if (ack !== 1'b1)      begin bad++; $display("FAIL wr_ack got=%b exp=1", ack); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h exp=a5", rx_data); end
        total++; if (rx_count !== 3'd1) begin bad++; $display("FAIL wr_count got=%0d exp=1", rx_count); end
        stb = 1'b0; tick;
        total++; if (ack !== 1'b0)      begin bad++; $display("FAIL wr_ack_drop got=%b exp=0", ack); end
        rx_ready = 1'b1; tick; rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wr_drain got=%b exp=0", rx_valid); end
    endtask

    task automatic test_fifo_full;
        logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] want [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        int lat;
        foreach (fill[i]) begin
            wr(fill[i], 1'b0, lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL fill_lat[%0d] got=%0d exp=1", i, lat); end
        end
        total++; if (rx_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", rx_count); end
        dir = 1'b0; tb_drv = 1'b1; tb_pin = 8'h55; stb = 1'b1;
        tick;
        tb_drv = 1'b0;   // byte must come from the capture register from here on
        for (int i = 0; i < 3; i++) begin
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL full_no_ack[%0d] got=%b exp=0", i, ack); end
            tick;
        end
        total++; if (rx_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", rx_count); end
        rx_ready = 1'b1; tick; rx_ready = 1'b0;
        total++; if (ack !== 1'b1)      begin bad++; $display("FAIL full_release_ack got=%b exp=1", ack); end
        total++; if (rx_count !== 3'd4) begin bad++; $display("FAIL full_release_count got=%0d exp=4", rx_count); end
        stb = 1'b0; tick;
        foreach (want[i]) begin
            total++; if (rx_data !== want[i]) begin bad++; $display("FAIL full_pop[%0d] got=%h exp=%h", i, rx_data, want[i]); end
            rx_ready = 1'b1; tick; rx_ready = 1'b0;
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", rx_valid); end
    endtask

    task automatic test_read;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rd_tx_ready_idle got=%b exp=1", tx_ready); end
        tx_data = 8'h3C; tx_valid = 1'b1; tick; tx_valid = 1'b0;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rd_tx_loaded got=%b exp=0", tx_ready); end
        dir = 1'b1; stb = 1'b1;
        for (int c = 1; c <= SETUP_CYC + 2; c++) begin
            tick;
            total++; if (pins !== 8'h3C) begin bad++; $display("FAIL rd_pins[N+%0d] got=%h exp=3c", c, pins); end
            total++; if (ack !== (c == SETUP_CYC + 2)) begin
                bad++; $display("FAIL rd_ack[N+%0d] got=%b exp=%b", c, ack, (c == SETUP_CYC + 2));
            end
        end
        stb = 1'b0; tick;
        total++; if (ack !== 1'b0)      begin bad++; $display("FAIL rd_ack_drop got=%b exp=0", ack); end
        total++; if (pins === 8'h3C)    begin bad++; $display("FAIL rd_pins_release got=%h exp=not driven", pins); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rd_tx_empty got=%b exp=1", tx_ready); end
        dir = 1'b0;
    endtask

    task automatic test_read_wait;
        int lat;
        dir = 1'b1; stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (ack !== 1'b0 || pins === 8'h3C) begin
                bad++; $display("FAIL rdw_idle[%0d] ack=%b pins=%h exp ack=0 undriven", i, ack, pins);
            end
        end
        tx_data = 8'h7E; tx_valid = 1'b1; tick; tx_valid = 1'b0;
        tick;
        total++; if (pins !== 8'h7E) begin bad++; $display("FAIL rdw_pins got=%h exp=7e", pins); end
        lat = 0;
        while (!ack && lat < 20) begin tick; lat++; end
        total++; if (lat !== SETUP_CYC + 1) begin bad++; $display("FAIL rdw_setup got=%0d exp=%0d", lat, SETUP_CYC + 1); end
        stb = 1'b0; tick; dir = 1'b0;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rdw_tx_empty got=%b exp=1", tx_ready); end
    endtask

    task automatic test_abort;
        int lat;
        tx_data = 8'h3C; tx_valid = 1'b1; tick; tx_valid = 1'b0;
        dir = 1'b1; stb = 1'b1; tick;
        total++; if (pins !== 8'h3C) begin bad++; $display("FAIL ab_pins_pre got=%h exp=3c", pins); end
        dir = 1'b0; tick;
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL ab_err got=%b exp=1", err); end
        total++; if (ack !== 1'b0)      begin bad++; $display("FAIL ab_ack got=%b exp=0", ack); end
        total++; if (pins === 8'h3C)    begin bad++; $display("FAIL ab_pins got=%h exp=not driven", pins); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ab_hold_kept got=%b exp=0", tx_ready); end
        tick;
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL ab_err_pulse got=%b exp=0", err); end
        // Back in IDLE with the hold intact: a fresh read completes with 3C.
        stb = 1'b0; dir = 1'b1; tick;
        stb = 1'b1; tick;
        total++; if (pins !== 8'h3C) begin bad++; $display("FAIL ab_reread_pins got=%h exp=3c", pins); end
        lat = 1;
        while (!ack && lat < 20) begin tick; lat++; end
        total++; if (lat !== SETUP_CYC + 2) begin bad++; $display("FAIL ab_reread_lat got=%0d exp=%0d", lat, SETUP_CYC + 2); end
        stb = 1'b0; tick; dir = 1'b0;
    endtask

    task automatic test_random;
        int lat, op;
        logic [7:0] b, pv;
        logic pop;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 2);
            b  = 8'($urandom_range(1, 255));
            if (op == 0) begin
                pop = (q.size() == 4) ? 1'b1 : 1'($urandom_range(0, 1));
                if (pop && q.size() > 0) begin
                    total++; if (rx_data !== q[0]) begin bad++; $display("FAIL rnd_head_pre[%0d] got=%h exp=%h", it, rx_data, q[0]); end
                    void'(q.pop_front());
                end
                q.push_back(b);
                wr(b, pop, lat);
                total++; if (lat !== 1) begin bad++; $display("FAIL rnd_wr_lat[%0d] got=%0d exp=1", it, lat); end
                total++; if (rx_count !== 3'(q.size()) || rx_data !== q[0]) begin
                    bad++; $display("FAIL rnd_wr[%0d] count=%0d head=%h exp count=%0d head=%h", it, rx_count, rx_data, q.size(), q[0]);
                end
            end else if (op == 1) begin
                if (q.size() > 0) begin
                    total++; if (rx_data !== q[0]) begin bad++; $display("FAIL rnd_pop[%0d] got=%h exp=%h", it, rx_data, q[0]); end
                    void'(q.pop_front());
                end else begin
                    total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
                        bad++; $display("FAIL rnd_empty[%0d] valid=%b data=%h exp 0/00", it, rx_valid, rx_data);
                    end
                end
                rx_ready = 1'b1; tick; rx_ready = 1'b0;
                total++; if (rx_count !== 3'(q.size())) begin bad++; $display("FAIL rnd_pop_count[%0d] got=%0d exp=%0d", it, rx_count, q.size()); end
            end else begin
                rd(b, pv, lat);
                total++; if (pv !== b) begin bad++; $display("FAIL rnd_rd_pins[%0d] got=%h exp=%h", it, pv, b); end
                total++; if (lat !== SETUP_CYC + 2 || tx_ready !== 1'b1) begin
                    bad++; $display("FAIL rnd_rd[%0d] lat=%0d tx_ready=%b exp lat=%0d tx_ready=1", it, lat, tx_ready, SETUP_CYC + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        while (q.size() > 0) begin rx_ready = 1'b1; tick; rx_ready = 1'b0; void'(q.pop_front()); end
        wr(8'h01, 1'b0, lat);
        wr(8'h02, 1'b0, lat);
        total++; if (rx_count !== 3'd2) begin bad++; $display("FAIL rm_pre_count got=%0d exp=2", rx_count); end
        tx_data = 8'h99; tx_valid = 1'b1; tick; tx_valid = 1'b0;
        dir = 1'b0; tb_drv = 1'b1; tb_pin = 8'h03; stb = 1'b1; tick; tb_drv = 1'b0;
        rst = 1'b1; stb = 1'b0; tick; rst = 1'b0;
        total++; if (ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rm_ack_err ack=%b err=%b exp 0/0", ack, err); end
        total++; if (rx_count !== 3'd0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            bad++; $display("FAIL rm_fifo count=%0d valid=%b data=%h exp 0/0/00", rx_count, rx_valid, rx_data);
        end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rm_tx_ready got=%b exp=1", tx_ready); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_fifo_full;
        test_read;
        test_read_wait;
        test_abort;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
